matrix_row_loader: RTL
======================

// Module: matrix_row_loader
// PURPOSE
//  Upstream fill stage for matrix_storage. Accepts a word-serial stream of weights (valid/ready),
//  packs each run of `size` words into one row, and drives the storage write port
//  (write_data/write_layer_index/write_row_index/is_write) one row per pulse.
//  One job loads num_layers complete size x size matrices starting at base_layer.
// PARAMETERS
//  size       3   words per row and rows per layer. Must match matrix_storage.
//  data_size  16  bits per word.
//  max_layer  5   layers in the storage. Used for the range check.
// PORTS
//  clk               in   1               rising-edge clock
//  reset             in   1               synchronous, active-high reset
//  start             in   1               job request; sampled only in IDLE
//  base_layer        in   32              first layer of the job; latched on an accepted start
//  num_layers        in   32              layers in the job; latched on an accepted start
//  in_data           in   data_size       stream word
//  in_valid          in   1               in_data valid
//  in_ready          out  1               loader can accept a word
//  write_data        out  data_size*size  packed row; word 0 in [size*data_size-1 -: data_size]
//  write_layer_index out  32              destination layer
//  write_row_index   out  32              destination row
//  is_write          out  1               one-cycle write strobe to storage
//  busy              out  1               high in FILL and WRITE
//  done              out  1               one-cycle pulse at job completion
//  error             out  1               sticky: last start request was illegal
// BEHAVIOUR
//  - All outputs are registered. Reset value of every output is 0. FSM enters IDLE; col/row/layer counters clear.
//  - A word transfers when in_valid && in_ready at a clk edge.
//  - IDLE: in_ready=0. On start, compute base_layer+num_layers in 33 bits.
//    - Illegal start: num_layers==0 or sum>max_layer. Set error=1, stay IDLE, issue no writes.
//    - Legal start: clear error, latch the arguments, row=0, layer=base_layer, go to FILL.
//  - FILL: in_ready=1. Each transfer stores word number col into slice
//    [(size-col)*data_size-1 -: data_size], then col++.
//    - Transfer with col==size-1: col=0, go to WRITE.
//  - WRITE (exactly 1 cycle): is_write=1, in_ready=0.
//    - write_data, write_row_index=row and write_layer_index=layer are valid in this cycle.
//    - Then, if row<size-1: row++, go to FILL.
//    - Else row=0. If this was the last layer of the job, go to DONE; otherwise layer++, go to FILL.
//  - DONE (1 cycle): done=1, then IDLE. busy=0 in IDLE and DONE.
//  - write_* index/data outputs hold their last value while is_write=0.
//  - start outside IDLE is ignored. It does not set error.
//  - in_valid outside FILL is ignored. Words are never dropped or duplicated.
//  - Throughput with continuous in_valid: size+1 cycles per row.
//    - The first is_write comes size cycles after the FILL entry edge.
//  - Reset mid-job takes priority over everything:
//    - next cycle is IDLE with is_write=0; no write is issued for a partial row.
//    - the partial row buffer is discarded.
//  - Row boundary: the write for row size-1 of layer L goes to layer L.
//    The next word then goes to (layer L+1, row 0, col 0).
// CONFIGURATION
//  MATRIX_LOADER_STATUS_EN defined:
//  - adds output rows_written [31:0], reset to 0.
//  - increments by 1 on every is_write cycle and wraps modulo 2^32.
//  - not cleared by start.
//  Not defined: the port and its counter do not exist; all other behaviour is identical.
// TESTING
//  1. Reset:
//     - Assert reset 2 cycles with start=1, in_valid=1.
//     - Required: all outputs 0, in_ready=0, no is_write.
//  2. Basic fill (size=3):
//     - Start base=1 num=1, then words 1..9 with in_valid held high.
//     - Required: 3 is_write pulses, each on the cycle after words 3, 6 and 9 are accepted.
//     - Pulse 1: row 0, layer 1, write_data={16'd1,16'd2,16'd3}.
//     - Pulse 2: row 1, layer 1, write_data={4,5,6}.
//     - Pulse 3: row 2, layer 1, write_data={7,8,9}.
//     - done on the cycle after pulse 3.
//  3. Multi-layer with gaps:
//     - Start base=3 num=2 (ends at max_layer); toggle in_valid 1/0 over 18 words.
//     - Required: 6 writes covering layers 3,4 and rows 0..2, packed identically to test 2; one done.
//  4. Range check:
//     - Start base=4 num=2 -> error=1, no writes, busy=0.
//     - Start num=0 -> error stays 1.
//     - Legal start -> error=0 on the next cycle.
//  5. Reset mid-job:
//     - Reset after word 5 of test 2.
//     - Required: is_write only for row 0. The new job's first write gets words 6..8 as row 0.
//  6. MATRIX_LOADER_STATUS_EN:
//     - Run test 2 twice.
//     - Required: rows_written=6. After reset, rows_written=0.

Source files
------------

// File: rtl/matrix_row_loader.sv
// matrix_row_loader: packs a word-serial stream into size-word rows and writes them into matrix_storage.
// Optional feature: define MATRIX_LOADER_STATUS_EN to add the rows_written counter output.
module matrix_row_loader #(
    parameter int size      = 3,
    parameter int data_size = 16,
    parameter int max_layer = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [31:0]               base_layer,
    input  logic [31:0]               num_layers,
    input  logic [data_size-1:0]      in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [data_size*size-1:0] write_data,
    output logic [31:0]               write_layer_index,
    output logic [31:0]               write_row_index,
    output logic                      is_write,
    output logic                      busy,
    output logic                      done,
    output logic                      error
`ifdef MATRIX_LOADER_STATUS_EN
    ,
    output logic [31:0]               rows_written
`endif
);
    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
    state_t                    state_q, state_d;
    logic [31:0]               col_q, col_d, row_q, row_d, layer_q, layer_d, last_q, last_d;
    logic [31:0]               wlayer_q, wlayer_d, wrow_q, wrow_d;
    logic [data_size*size-1:0] buf_q, buf_d, wdata_q, wdata_d;
    logic                      in_ready_q, is_write_q, busy_q, done_q, error_q, error_d;
    logic [32:0]               sum;
    logic                      legal;

    assign sum   = {1'b0, base_layer} + {1'b0, num_layers};
    assign legal = (num_layers != 32'd0) && (sum <= 33'(max_layer));

    // Next state, counters, row buffer and write-port capture; in_ready is high exactly in FILL
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        layer_d  = layer_q;
        last_d   = last_q;
        buf_d    = buf_q;
        error_d  = error_q;
        wdata_d  = wdata_q;
        wlayer_d = wlayer_q;
        wrow_d   = wrow_q;
        case (state_q)
            IDLE: if (start) begin
                error_d = !legal;
                if (legal) begin
                    col_d   = '0;
                    row_d   = '0;
                    layer_d = base_layer;
                    last_d  = base_layer + num_layers - 32'd1;
                    state_d = FILL;
                end
            end
            FILL: if (in_valid) begin
                buf_d[(size-1-col_q)*data_size +: data_size] = in_data;
                if (col_q == size-1) begin
                    col_d    = '0;
                    wdata_d  = buf_d;
                    wlayer_d = layer_q;
                    wrow_d   = row_q;
                    state_d  = WRITE;
                end else begin
                    col_d = col_q + 32'd1;
                end
            end
            WRITE: if (row_q < size-1) begin
                row_d   = row_q + 32'd1;
                state_d = FILL;
            end else begin
                row_d = '0;
                if (layer_q == last_q) begin
                    state_d = DONE;
                end else begin
                    layer_d = layer_q + 32'd1;
                    state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; strobes are decoded from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            layer_q    <= '0;
            last_q     <= '0;
            buf_q      <= '0;
            wdata_q    <= '0;
            wlayer_q   <= '0;
            wrow_q     <= '0;
            error_q    <= 1'b0;
            in_ready_q <= 1'b0;
            is_write_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            layer_q    <= layer_d;
            last_q     <= last_d;
            buf_q      <= buf_d;
            wdata_q    <= wdata_d;
            wlayer_q   <= wlayer_d;
            wrow_q     <= wrow_d;
            error_q    <= error_d;
            in_ready_q <= state_d == FILL;
            is_write_q <= state_d == WRITE;
            busy_q     <= (state_d == FILL) || (state_d == WRITE);
            done_q     <= state_d == DONE;
        end
    end

    assign in_ready          = in_ready_q;
    assign write_data        = wdata_q;
    assign write_layer_index = wlayer_q;
    assign write_row_index   = wrow_q;
    assign is_write          = is_write_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;

`ifdef MATRIX_LOADER_STATUS_EN
    logic [31:0] rows_written_q;

    // Count write strobes across jobs; wraps at 2^32
    always_ff @(posedge clk) begin
        if (reset) rows_written_q <= '0;
        else if (is_write_q) rows_written_q <= rows_written_q + 32'd1;
    end

    assign rows_written = rows_written_q;
`endif
endmodule
